// File: rtl/fft_uart_sender_if.sv
// FIFO read port and UART TX handshake bundled between the FFT frame sender
// (master) and the FIFO / UART side (slave).
interface fft_uart_sender_if;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;

    modport master (
        input  fifo_empty, fifo_dout, tx_busy,
        output fifo_rd_en, tx_start, tx_data
    );

    modport slave (
        output fifo_empty, fifo_dout, tx_busy,
        input  fifo_rd_en, tx_start, tx_data
    );
endinterface

// File: rtl/fft_uart_sender.sv
// Drains one FFT frame from the buffer FIFO and streams it MSB-byte first to the UART.
// Define FFT_UART_HEADER_EN to prefix each frame with the sync bytes A5, 5A.
module fft_uart_sender #(
    parameter int FRAME_WORDS = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    fft_uart_sender_if.master   bus,
    output logic                busy,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef FFT_UART_HEADER_EN
        S_HDR   = 3'd1,
`endif
        S_RD    = 3'd2,
        S_LATCH = 3'd3,
        S_SEND  = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd3:    return word[31:24];
            2'd2:    return word[23:16];
            2'd1:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

    state_t             state_r, state_n;
    logic               rd_en_r, rd_en_n;
    logic               tx_start_r, tx_start_n;
    logic [7:0]         tx_data_r, tx_data_n;
    logic               busy_r, busy_n;
    logic               frame_done_r, frame_done_n;
    logic [31:0]        word_reg_r, word_reg_n;
    logic [1:0]         byte_idx_r, byte_idx_n;
    logic [CNT_W-1:0]   word_cnt_r, word_cnt_n;
    logic               abort_pend_r, abort_pend_n;
    logic               abort_cut_s;
`ifdef FFT_UART_HEADER_EN
    logic               hdr_active_r, hdr_active_n;
    logic               hdr_second_r, hdr_second_n;
`endif

    // Abort drops straight to IDLE except while a byte is in flight in the UART
    assign abort_cut_s = abort && (state_r != S_IDLE) && (state_r != S_WAIT);

    // Next-state and next-output logic; strobes are decided one cycle ahead so they leave registered
    always_comb begin
        state_n      = state_r;
        rd_en_n      = 1'b0;
        tx_start_n   = 1'b0;
        tx_data_n    = tx_data_r;
        frame_done_n = 1'b0;
        word_reg_n   = word_reg_r;
        byte_idx_n   = byte_idx_r;
        word_cnt_n   = word_cnt_r;
`ifdef FFT_UART_HEADER_EN
        hdr_active_n = hdr_active_r;
        hdr_second_n = hdr_second_r;
`endif
        if (abort_cut_s) begin
            state_n = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        word_cnt_n = '0;
                        byte_idx_n = 2'd0;
`ifdef FFT_UART_HEADER_EN
                        hdr_active_n = 1'b1;
                        hdr_second_n = 1'b0;
                        state_n      = S_HDR;
`else
                        rd_en_n = !bus.fifo_empty;
                        state_n = S_RD;
`endif
                    end else begin
                        state_n = S_IDLE;
                    end
                end
`ifdef FFT_UART_HEADER_EN
                S_HDR: begin
                    if (!bus.tx_busy) begin
                        tx_start_n = 1'b1;
                        tx_data_n  = hdr_second_r ? 8'h5A : 8'hA5;
                        state_n    = S_WAIT;
                    end else begin
                        state_n = S_HDR;
                    end
                end
`endif
                S_RD: begin
                    // rd_en_r high means the strobe is on the bus this cycle
                    if (rd_en_r) begin
                        state_n = S_LATCH;
                    end else if (!bus.fifo_empty) begin
                        rd_en_n = 1'b1;
                    end else begin
                        rd_en_n = 1'b0;
                    end
                end
                S_LATCH: begin
                    word_reg_n = bus.fifo_dout;
                    byte_idx_n = 2'd3;
                    if (!bus.tx_busy) begin
                        tx_start_n = 1'b1;
                        tx_data_n  = bus.fifo_dout[31:24];
                        state_n    = S_WAIT;
                    end else begin
                        state_n = S_SEND;
                    end
                end
                S_SEND: begin
                    if (!bus.tx_busy) begin
                        tx_start_n = 1'b1;
                        tx_data_n  = sel_byte(word_reg_r, byte_idx_r);
                        state_n    = S_WAIT;
                    end else begin
                        state_n = S_SEND;
                    end
                end
                S_WAIT: begin
                    // tx_start_r marks the first WAIT cycle, before the UART can raise busy
                    if (tx_start_r || bus.tx_busy) begin
                        state_n = S_WAIT;
                    end else if (abort_pend_r || abort) begin
                        state_n = S_IDLE;
`ifdef FFT_UART_HEADER_EN
                    end else if (hdr_active_r) begin
                        if (hdr_second_r) begin
                            hdr_active_n = 1'b0;
                            rd_en_n      = !bus.fifo_empty;
                            state_n      = S_RD;
                        end else begin
                            hdr_second_n = 1'b1;
                            state_n      = S_HDR;
                        end
`endif
                    end else if (byte_idx_r != 2'd0) begin
                        byte_idx_n = byte_idx_r - 2'd1;
                        state_n    = S_SEND;
                    end else if (word_cnt_r == LAST_WORD) begin
                        state_n = S_DONE;
                    end else begin
                        word_cnt_n = word_cnt_r + CNT_W'(1);
                        rd_en_n    = !bus.fifo_empty;
                        state_n    = S_RD;
                    end
                end
                S_DONE: begin
                    frame_done_n = 1'b1;
                    state_n      = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
        abort_pend_n = (state_n == S_IDLE) ? 1'b0 : (abort_pend_r | abort);
        busy_n       = (state_n != S_IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            rd_en_r      <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            word_reg_r   <= 32'h0000_0000;
            byte_idx_r   <= 2'd0;
            word_cnt_r   <= '0;
            abort_pend_r <= 1'b0;
`ifdef FFT_UART_HEADER_EN
            hdr_active_r <= 1'b0;
            hdr_second_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_n;
            rd_en_r      <= rd_en_n;
            tx_start_r   <= tx_start_n;
            tx_data_r    <= tx_data_n;
            busy_r       <= busy_n;
            frame_done_r <= frame_done_n;
            word_reg_r   <= word_reg_n;
            byte_idx_r   <= byte_idx_n;
            word_cnt_r   <= word_cnt_n;
            abort_pend_r <= abort_pend_n;
`ifdef FFT_UART_HEADER_EN
            hdr_active_r <= hdr_active_n;
            hdr_second_r <= hdr_second_n;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en_r;
    assign bus.tx_start   = tx_start_r;
    assign bus.tx_data    = tx_data_r;
    assign busy           = busy_r;
    assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_fft_uart_sender.sv
// Bench for fft_uart_sender with a FIFO model, a 10-cycle UART busy model and a byte scoreboard.
module tb_fft_uart_sender;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic frame_done;

    fft_uart_sender_if bus();

    fft_uart_sender #(.FRAME_WORDS(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

`ifdef FFT_UART_HEADER_EN
    localparam int HDR_BYTES = 2;
`else
    localparam int HDR_BYTES = 0;
`endif

    // FIFO model: data valid one cycle after the read strobe
    logic [31:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        flush = 1'b0;
    logic [31:0] fifo_dout_r = 32'h0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = fifo_dout_r;

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_dout_r <= mem[rd_ptr % 64];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    // UART model: busy for 10 cycles starting the cycle after tx_start
    int uart_cnt = 0;
    assign bus.tx_busy = (uart_cnt != 0);

    always @(posedge clk) begin
        if (bus.tx_start) uart_cnt <= 10;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end

    // Output monitor
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int tx_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int rd_while_empty = 0;

    always @(negedge clk) begin
        if (bus.tx_start) begin
            obs_q.push_back(bus.tx_data);
            tx_cnt <= tx_cnt + 1;
        end
        if (bus.fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (bus.fifo_empty) rd_while_empty <= rd_while_empty + 1;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic push_hdr_exp();
        if (HDR_BYTES == 2) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic compare_scoreboard(input string name);
        logic [8:0] a;
        logic [7:0] e;
        check({name, "_byte_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = 9'h100;
            if (obs_q.size() > 0) a = {1'b0, obs_q.pop_front()};
            check({name, "_tx_byte"}, 64'(a), {55'd0, 1'b0, e});
        end
        obs_q.delete();
    endtask

    task automatic wait_tx(input int target, input int base);
        int c = 0;
        while (((tx_cnt - base) < target) && (c < 600)) begin
            @(negedge clk);
            c++;
        end
        check("tx_wait_bound", 64'((tx_cnt - base) >= target), 64'd1);
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [63:0] exp_bytes;
        bit          restart;
    } vec_t;

    task automatic run_frame(input vec_t v, input bit timing, input string name);
        int  b_tx, b_rd, b_done, b_empty, n_exp, c;
        bit  ok;
        b_tx = tx_cnt; b_rd = rd_cnt; b_done = done_cnt; b_empty = rd_while_empty;
        push_hdr_exp();
        for (int k = 0; k < 8; k++) exp_q.push_back(v.exp_bytes[63 - 8 * k -: 8]);
        n_exp = exp_q.size();
        push_word(v.w0);
        push_word(v.w1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (timing) begin
`ifndef FFT_UART_HEADER_EN
            check("start_to_rd", 64'(bus.fifo_rd_en), 64'd1);
            @(negedge clk);
            check("rd_single_cycle", 64'(bus.fifo_rd_en), 64'd0);
            @(negedge clk);
            check("rd_to_tx_start", 64'(bus.tx_start), 64'd1);
`endif
            wait_tx(n_exp, b_tx);
            c = 0;
            while (bus.tx_busy && c < 20) begin
                @(negedge clk);
                c++;
            end
            @(negedge clk);
            check("done_not_early", 64'(frame_done), 64'd0);
            @(negedge clk);
            check("busy_fall_to_done", 64'(frame_done), 64'd1);
        end
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != b_done) begin
                ok = 1'b1;
                break;
            end
            start = (v.restart && i == 40) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done_seen"}, 64'(ok), 64'd1);
        repeat (5) @(negedge clk);
        compare_scoreboard(name);
        check({name, "_rd_pulses"}, 64'(rd_cnt - b_rd), 64'd2);
        check({name, "_tx_pulses"}, 64'(tx_cnt - b_tx), 64'(8 + HDR_BYTES));
        check({name, "_done_pulses"}, 64'(done_cnt - b_done), 64'd1);
        check({name, "_busy_idle"}, 64'(busy), 64'd0);
        check({name, "_rd_while_empty"}, 64'(rd_while_empty - b_empty), 64'd0);
    endtask

    vec_t vecs[3];

    initial begin
        int b_tx, b_rd, b_done;
        vecs[0] = '{32'h11223344, 32'hAABBCCDD, 64'h11223344AABBCCDD, 1'b0};
        vecs[1] = '{32'h00FF8001, 32'h7E5A3CC3, 64'h00FF80017E5A3CC3, 1'b1};
        vecs[2] = '{32'hDEADBEEF, 32'h01020304, 64'hDEADBEEF01020304, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {59'd0, bus.fifo_rd_en, bus.tx_start, busy, frame_done, 1'b0},
              64'd0);
        check("reset_tx_data", 64'(bus.tx_data), 64'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_frame(vecs[i], (i == 0), $sformatf("vec%0d", i));

        // FIFO empty at start: stall without strobes, then read one cycle after it fills
        b_tx = tx_cnt; b_rd = rd_cnt; b_done = done_cnt;
        push_hdr_exp();
        for (int k = 0; k < 8; k++) exp_q.push_back(vecs[2].exp_bytes[63 - 8 * k -: 8]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20 + HDR_BYTES * 15) @(negedge clk);
        check("empty_no_rd", 64'(rd_cnt - b_rd), 64'd0);
        check("empty_busy", 64'(busy), 64'd1);
        push_word(vecs[2].w0);
        @(negedge clk);
        check("empty_release_rd", 64'(bus.fifo_rd_en), 64'd1);
        push_word(vecs[2].w1);
        wait_tx(8 + HDR_BYTES, b_tx);
        repeat (20) @(negedge clk);
        compare_scoreboard("empty");
        check("empty_done", 64'(done_cnt - b_done), 64'd1);
        check("empty_rd_while_empty", 64'(rd_while_empty), 64'd0);

        // Abort during WAIT of the second byte of word 0
        b_tx = tx_cnt; b_rd = rd_cnt; b_done = done_cnt;
        push_hdr_exp();
        exp_q.push_back(8'hCA);
        exp_q.push_back(8'hFE);
        push_word(32'hCAFEF00D);
        push_word(32'h12345678);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_tx(2 + HDR_BYTES, b_tx);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk);
        check("abort_byte_in_flight", 64'(busy), 64'd1);
        repeat (40) @(negedge clk);
        compare_scoreboard("abort");
        check("abort_tx_pulses", 64'(tx_cnt - b_tx), 64'(2 + HDR_BYTES));
        check("abort_no_done", 64'(done_cnt - b_done), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        check("abort_rd_pulses", 64'(rd_cnt - b_rd), 64'd1);
        check("abort_word_left", 64'(wr_ptr - rd_ptr), 64'd1);
        do_flush();

        // Reset mid-frame, then a clean frame
        b_tx = tx_cnt;
        push_word(32'h55667788);
        push_word(32'h99AABBCC);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_tx(3 + HDR_BYTES, b_tx);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {59'd0, bus.fifo_rd_en, bus.tx_start, busy, frame_done, 1'b0},
              64'd0);
        check("midreset_tx_data", 64'(bus.tx_data), 64'h00);
        @(negedge clk);
        rst_n = 1'b1;
        do_flush();
        exp_q.delete();
        obs_q.delete();
        repeat (15) @(negedge clk);
        run_frame(vecs[0], 1'b0, "after_reset");

        // start together with abort in IDLE
        b_tx = tx_cnt; b_rd = rd_cnt; b_done = done_cnt;
        push_word(32'h0BADF00D);
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        repeat (10) @(negedge clk);
        check("start_abort_idle", 64'(busy), 64'd0);
        check("start_abort_no_rd", 64'(rd_cnt - b_rd), 64'd0);
        check("start_abort_no_tx", 64'(tx_cnt - b_tx), 64'd0);
        check("start_abort_no_done", 64'(done_cnt - b_done), 64'd0);
        do_flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
